cpld_ram_arbiter: RTL
=====================

Name: cpld_ram_arbiter

Overview:
- Shares the 512K expansion SRAM between the CPC CPU and a secondary host loader port, such as a microcontroller used for preloading or inspecting banks.
- Contains the bank-select register, now captured synchronously on clk, and the CPU mapping decode.
- A clocked arbiter inserts host SRAM cycles while the CPU is not accessing expansion RAM.
- If the CPU accesses expansion RAM while a host cycle is running, the arbiter stalls the CPU through the wait line.

Parameters:
- HOST_CYCLES, 3: clocks per host SRAM access; legal range 2..7.
- REC_CYCLES, 1: turnaround clocks after a host access before the CPU or host may use the RAM; legal range 1..3.

Ports:
- clk  input  1  CPC 4MHz clock
- reset_b  input  1  asynchronous active-low reset
- adr15, adr14  input  1 each  CPU address bits 15:14
- iorq_b, mreq_b, wr_b, rd_b, ramrd_b  input  1 each  CPU bus strobes, active low
- data  input  8  CPU data bus
- host_req  input  1  host access request, level; hold until host_ack
- host_we  input  1  1 = write, 0 = read; held with host_req
- host_adrhi  input  5  host 16K block number
- host_ack  output  1  one-clock pulse in the last host access cycle
- host_bufen_b  output  1  enables the host address/data buffers onto the SRAM bus
- wait_b  output  1  CPU wait request; low stalls the CPU
- ramadrhi  output  5  SRAM address bits 18:14
- ramcs_b, ramoe_b, ramwe_b  output  1 each  SRAM strobes
- ramdis  output  1  high disables CPC internal RAM

Behaviour:
- Bank register ramblock_q[5:0]:
  - Loaded from data[5:0] on rising clk when iorq_b=0, wr_b=0, adr15=0 and data[7:6]=11.
  - Reset value is 0.
- Mapping, with mode = ramblock_q[2:0], bank = ramblock_q[5:3] and A = {adr15,adr14}. hit=1 means the CPU access goes to expansion RAM:
  - mode 0: no hit.
  - mode 2: hit for all A; ramadrhi = {bank,A}.
  - modes 1 and 3: hit only for A=11; ramadrhi = {bank,11}.
  - modes 4..7: hit only for A=01; ramadrhi = {bank,ramblock_q[1:0]}.
  - Mapping outputs are combinational from ramblock_q and A.
- cpu_ext = !mreq_b & hit.
- ramdis = cpu_ext in every state (combinational).
- Arbiter FSM states IDLE, ARM, HOST, REC; reset state is IDLE.
  - IDLE: if host_req=1 and mreq_b=1, go to ARM.
  - ARM: re-samples the idle condition.
    - If host_req=1 and mreq_b=1, go to HOST and load counter cnt=0.
    - Otherwise return to IDLE.
  - HOST:
    - cnt increments each clock.
    - At cnt = HOST_CYCLES-1: assert host_ack for that clock, then go to REC.
  - REC: hold for REC_CYCLES clocks, then go to IDLE. A request still pending re-arbitrates through ARM, so there is no back-to-back bypass.
- SRAM drive in IDLE and ARM (CPU owns the RAM):
  - ramcs_b = !cpu_ext
  - ramadrhi = mapping
  - ramoe_b = ramrd_b | !cpu_ext
  - ramwe_b = wr_b | !cpu_ext
  - host_bufen_b = 1
- SRAM drive in HOST:
  - ramcs_b = 0
  - ramadrhi = host_adrhi
  - host_bufen_b = 0
  - Reads: ramoe_b = 0 for all cycles.
  - Writes: ramoe_b = 1; ramwe_b = 0 for cnt 1..HOST_CYCLES-2, and 1 at cnt 0 (address setup) and at the last cycle (data hold).
  - The registered host strobes are glitch-free.
- SRAM drive in REC:
  - ramcs_b = 1, ramoe_b = 1, ramwe_b = 1, host_bufen_b = 1.
  - ramadrhi holds host_adrhi.
- Conflict handling:
  - wait_b = !(cpu_ext & state in {HOST, REC}), combinational.
  - The CPU stays stalled until the FSM returns to IDLE; the CPU access then completes normally.
  - CPU accesses to internal RAM (no hit) are never stalled.
- A bank register write during HOST takes effect immediately for mapping. It does not alter the host access in progress.
- Reset asserted mid-HOST:
  - All outputs go to reset values asynchronously.
  - Reset values: host_ack=0, host_bufen_b=1, wait_b=1, ramwe_b=1, ramoe_b=1, ramblock_q=0 (so ramcs_b=1 and ramdis=0).
  - The host access is aborted with no ack; the host must re-request.
- host_req dropped before ack:
  - In ARM: return to IDLE.
  - In HOST: the cycle completes and the ack is still pulsed; the host ignores it.

Test Plan:
- Write 0x7F00 with data 0xC2, then CPU read at 0x4000 -> ramblock_q=02; ramcs_b=0, ramdis=1, ramadrhi=00001; wait_b=1.
- Mode 0xC1, then CPU read at 0x8000 -> ramcs_b=1, ramdis=0. CPU read at 0xC000 -> ramadrhi=00011.
- host_req=1, host_we=1, host_adrhi=10101 with CPU idle -> ARM, then HOST for 3 clocks. ramwe_b low only in the middle cycle, host_ack pulses in cycle 3, then REC for 1 clock.
- During HOST, CPU mreq_b=0 at 0xC000 with mode 0xC3 -> wait_b=0 until IDLE. Then ramadrhi=00011 and ramcs_b=0. Repeat at 0x0000 (no hit) -> wait_b stays 1.
- host_req asserted while mreq_b=0 -> FSM stays in IDLE/ARM. It enters HOST only after two consecutive clocks with mreq_b=1.
- Assert reset_b=0 at HOST cnt=1 of a write -> ramwe_b=1 and host_bufen_b=1 immediately, no host_ack, ramblock_q=0.

Source files
------------

// File: rtl/cpld_ram_arbiter.sv
// Expansion SRAM arbiter: CPU bank register and mapping decode, plus a clocked
// arbiter that slips host loader cycles into CPU idle time and stalls conflicts.
module cpld_ram_arbiter #(
    parameter int unsigned HOST_CYCLES = 3,
    parameter int unsigned REC_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       adr15,
    input  logic       adr14,
    input  logic       iorq_b,
    input  logic       mreq_b,
    input  logic       wr_b,
    input  logic       rd_b,
    input  logic       ramrd_b,
    input  logic [7:0] data,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [4:0] host_adrhi,
    output logic       host_ack,
    output logic       host_bufen_b,
    output logic       wait_b,
    output logic [4:0] ramadrhi,
    output logic       ramcs_b,
    output logic       ramoe_b,
    output logic       ramwe_b,
    output logic       ramdis
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] HOST_LAST = CNT_W'(HOST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LAST   = CNT_W'(HOST_CYCLES - 2);
    localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(REC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HOST = 2'd2,
        REC  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       ramblock_q, ramblock_d;
    logic [4:0]       host_adr_q, host_adr_d;
    logic             host_we_q, host_we_d;
    logic             host_ack_q, host_ack_d;
    logic             hwe_b_q, hwe_b_d;
    logic             hoe_b_q, hoe_b_d;
    logic             hbufen_b_q, hbufen_b_d;

    logic       hit;
    logic [4:0] map_adr;
    logic       cpu_ext;
    logic       host_busy;
    logic       unused_rd;

    // rd_b is not needed: SRAM output enable follows ramrd_b
    assign unused_rd = rd_b;

    // Bank select register, written by OUT to &7Fxx with data[7:6] = 11
    always_comb begin : bank_next
        ramblock_d = ramblock_q;
        if (!iorq_b && !wr_b && !adr15 && (data[7:6] == 2'b11)) begin
            ramblock_d = data[5:0];
        end
    end

    // CPU mapping decode
    always_comb begin : map_decode
        hit     = 1'b0;
        map_adr = {ramblock_q[5:3], adr15, adr14};
        case (ramblock_q[2:0])
            3'd0: hit = 1'b0;
            3'd2: begin
                hit     = 1'b1;
                map_adr = {ramblock_q[5:3], adr15, adr14};
            end
            3'd1, 3'd3: begin
                hit     = adr15 & adr14;
                map_adr = {ramblock_q[5:3], 2'b11};
            end
            default: begin
                hit     = !adr15 & adr14;
                map_adr = {ramblock_q[5:3], ramblock_q[1:0]};
            end
        endcase
    end

    assign cpu_ext   = !mreq_b & hit;
    assign host_busy = (state_q == HOST) || (state_q == REC);
    assign ramdis    = cpu_ext;
    assign wait_b    = !(cpu_ext && host_busy);

    // Arbiter next state; host strobes are precomputed from the next state so they leave flops
    always_comb begin : fsm_next
        state_d    = state_q;
        cnt_d      = cnt_q;
        host_adr_d = host_adr_q;
        host_we_d  = host_we_q;
        host_ack_d = 1'b0;
        hwe_b_d    = 1'b1;
        hoe_b_d    = 1'b1;
        hbufen_b_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (host_req && mreq_b) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (host_req && mreq_b) begin
                    state_d    = HOST;
                    cnt_d      = '0;
                    host_adr_d = host_adrhi;
                    host_we_d  = host_we;
                end else begin
                    state_d = IDLE;
                end
            end
            HOST: begin
                if (cnt_q == HOST_LAST) begin
                    state_d = REC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REC: begin
                if (cnt_q == REC_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == HOST) begin
            hbufen_b_d = 1'b0;
            hoe_b_d    = host_we_d;
            hwe_b_d    = !(host_we_d && (cnt_d >= CNT_W'(1)) && (cnt_d <= WE_LAST));
            host_ack_d = (cnt_d == HOST_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin : regs
        if (!reset_b) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ramblock_q <= '0;
            host_adr_q <= '0;
            host_we_q  <= 1'b0;
            host_ack_q <= 1'b0;
            hwe_b_q    <= 1'b1;
            hoe_b_q    <= 1'b1;
            hbufen_b_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ramblock_q <= ramblock_d;
            host_adr_q <= host_adr_d;
            host_we_q  <= host_we_d;
            host_ack_q <= host_ack_d;
            hwe_b_q    <= hwe_b_d;
            hoe_b_q    <= hoe_b_d;
            hbufen_b_q <= hbufen_b_d;
        end
    end

    // SRAM bus owner mux: CPU in IDLE/ARM, host flops in HOST, parked in REC
    always_comb begin : sram_drive
        ramcs_b  = !cpu_ext;
        ramadrhi = map_adr;
        ramoe_b  = ramrd_b | !cpu_ext;
        ramwe_b  = wr_b | !cpu_ext;
        case (state_q)
            HOST: begin
                ramcs_b  = 1'b0;
                ramadrhi = host_adr_q;
                ramoe_b  = hoe_b_q;
                ramwe_b  = hwe_b_q;
            end
            REC: begin
                ramcs_b  = 1'b1;
                ramadrhi = host_adr_q;
                ramoe_b  = 1'b1;
                ramwe_b  = 1'b1;
            end
            default: ;
        endcase
    end

    assign host_ack     = host_ack_q;
    assign host_bufen_b = hbufen_b_q;

endmodule
